multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Registered control-state machine for the multicycle RISC-V datapath. Successor to the combinational next-state decoder.
- Holds the state register and adds a memory ready/wait handshake with a timeout, a global stall, an illegal-encoding trap state, and a retired-instruction counter.
- Parametrised in opcode width, func_3 width, timeout and counter width.
- Sits between the instruction register (op, func_3) and the datapath control decoder, which consumes `state`.

Parameters:
- OP_W, 2, width of op field; op values >= 4 are illegal.
- F3_W, 3, width of func_3 field.
- MEM_TIMEOUT, 15, maximum wait cycles for mem_ready; 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- op  in  OP_W  instruction class from IR.
- func_3  in  F3_W  memory sub-op from IR.
- mem_ready  in  1  memory completes the current access this cycle.
- stall  in  1  freeze state and counters.
- trap_clr  in  1  leave TRAP, go to FETCH.
- state  out  4  registered current state.
- mem_req  out  1  memory access request.
- instr_done  out  1  one-cycle pulse on the final cycle of an instruction.
- trap  out  1  high while in TRAP.
- timeout_err  out  1  sticky; set on memory timeout, cleared by trap_clr.
- instr_count  out  CNT_W  retired-instruction count.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
  - Reset forces state=FETCH, wait_cnt=0, instr_count=0, timeout_err=0, regardless of clk.
  - Reset asserted mid-access abandons the access; there is no pending-request memory.
- State encodings:
  - FETCH=0, DECODE=1, MEM_ADR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5.
  - EXECUTE_R=6, ALU_WB=7, EXECUTE_I=8, BNEZ=9, TRAP=10.
  - Codes 11-15 go to FETCH on the next edge.
- Priority per edge: reset > stall > normal transition.
  - stall=1 holds state, wait_cnt and instr_count.
  - instr_done is forced 0 while stall=1.
  - mem_req keeps its state-derived value while stalled.
- Transitions:
  - FETCH -> DECODE when mem_ready; else stay.
  - DECODE: op 0 -> EXECUTE_R; 1 -> EXECUTE_I; 2 -> MEM_ADR; 3 -> BNEZ; any other value -> TRAP.
  - MEM_ADR: func_3 0 -> MEM_READ; 1 -> MEM_WRITE; any other value -> TRAP.
  - MEM_READ -> MEM_WB when mem_ready; else stay.
  - MEM_WRITE -> FETCH when mem_ready; else stay.
  - MEM_WB -> FETCH. EXECUTE_R -> ALU_WB. EXECUTE_I -> ALU_WB. ALU_WB -> FETCH. BNEZ -> FETCH.
  - TRAP stays until trap_clr=1, then -> FETCH on the next edge.
- mem_req = 1 in FETCH, MEM_READ and MEM_WRITE; 0 elsewhere (combinational from state).
- Timeout:
  - wait_cnt increments each unstalled cycle spent in a mem_req state with mem_ready=0.
  - wait_cnt clears on any state change.
  - If MEM_TIMEOUT>0 and wait_cnt==MEM_TIMEOUT with mem_ready still 0, the next state is TRAP and timeout_err is set.
  - mem_ready=1 in that same cycle wins: the access completes, no trap.
  - wait_cnt width is clog2(MEM_TIMEOUT+1), minimum 1.
- instr_done (combinational) is 1 when unstalled and any of:
  - state is MEM_WB, ALU_WB or BNEZ;
  - state is MEM_WRITE and mem_ready=1.
- instr_count increments on the edge where instr_done=1. It wraps from all-ones to 0. TRAP entries never count.
- trap = (state==TRAP). trap_clr outside TRAP is ignored, except that it clears timeout_err.
- op and func_3 are sampled combinationally in DECODE and MEM_ADR only. The IR must hold them stable during those states.

Decomposition:
- Shared package ctrl_pkg holds the state encodings (4-bit constants, including TRAP) and the op/func_3 class constants. The datapath decoder imports the same package.
- One natural sub-module: ctrl_wait_timer (wait_cnt plus timeout compare, parametrised by MEM_TIMEOUT).
- Next-state logic, state register and instr_count stay in the top module.

Test Plan:
- R-type: op=0, mem_ready=1 in FETCH.
  - Required: state sequence 0,1,6,7,0; instr_done high only in state 7; instr_count goes 0 -> 1.
- Load with wait:
  - Stimulus: op=2, func_3=0; mem_ready low for 3 cycles in MEM_READ.
  - Required: state sequence 0,1,2,3,3,3,3,4,0; mem_req high throughout the state-3 cycles; count +1.
- Store:
  - Stimulus: op=2, func_3=1; mem_ready high on the 2nd MEM_WRITE cycle.
  - Required: instr_done pulses in that cycle; next state 0.
- Illegal encodings:
  - OP_W=3 with op=5 -> state 10, trap=1, held until trap_clr; then state 0; count unchanged.
  - func_3=2 in MEM_ADR -> state 10.
- Timeout:
  - Stimulus: MEM_TIMEOUT=4, mem_ready held 0 in FETCH.
  - Required: state 0 for 5 cycles, then 10; timeout_err=1. trap_clr -> state 0, timeout_err=0.
  - Repeat with mem_ready=1 on the 5th cycle: no trap.
- Stall and reset:
  - stall=1 for 3 cycles in EXECUTE_I: state holds at 8 and instr_done=0.
  - Asynchronous reset pulse asserted mid-cycle in MEM_READ: state=0 and instr_count=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle control FSM and the datapath control decoder.
package ctrl_pkg;

   localparam int unsigned STATE_W = 4;

   typedef enum logic [STATE_W-1:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADR   = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE_R = 4'd6,
      S_ALU_WB    = 4'd7,
      S_EXECUTE_I = 4'd8,
      S_BNEZ      = 4'd9,
      S_TRAP      = 4'd10
   } state_t;

   localparam int unsigned OP_RTYPE = 0;
   localparam int unsigned OP_ITYPE = 1;
   localparam int unsigned OP_MEM   = 2;
   localparam int unsigned OP_BNEZ  = 3;

   localparam int unsigned F3_LOAD  = 0;
   localparam int unsigned F3_STORE = 1;

   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control FSM boundary: IR fields and memory/stall inputs in, state and status out.
interface multicycle_ctrl_fsm_if
   import ctrl_pkg::*;
#(
   parameter int unsigned OP_W  = 2,
   parameter int unsigned F3_W  = 3,
   parameter int unsigned CNT_W = 32
);

   logic [OP_W-1:0]    op;
   logic [F3_W-1:0]    func_3;
   logic               mem_ready;
   logic               stall;
   logic               trap_clr;
   logic [STATE_W-1:0] state;
   logic               mem_req;
   logic               instr_done;
   logic               trap;
   logic               timeout_err;
   logic [CNT_W-1:0]   instr_count;

   modport master (
      output op, func_3, mem_ready, stall, trap_clr,
      input  state, mem_req, instr_done, trap, timeout_err, instr_count
   );

   modport slave (
      input  op, func_3, mem_ready, stall, trap_clr,
      output state, mem_req, instr_done, trap, timeout_err, instr_count
   );

endinterface

// File: rtl/ctrl_wait_timer.sv
// Counts unanswered memory-wait cycles and flags a timeout at MEM_TIMEOUT (0 disables).
module ctrl_wait_timer #(
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic clk,
   input  logic reset,
   input  logic i_en,
   input  logic i_wait,
   input  logic i_state_chg,
   output logic o_timeout
);

   localparam int unsigned WAIT_W = (MEM_TIMEOUT == 0) ? 1 : $clog2(MEM_TIMEOUT + 1);

   logic [WAIT_W-1:0] r_wait_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wait_cnt <= '0;
      end else if (i_en) begin
         if (i_state_chg) begin
            r_wait_cnt <= '0;
         end else if (i_wait && (MEM_TIMEOUT != 0)) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         end
      end
   end

   assign o_timeout = (MEM_TIMEOUT != 0) && i_wait && (r_wait_cnt == WAIT_W'(MEM_TIMEOUT));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Registered multicycle RISC-V control FSM with memory handshake, timeout trap,
// global stall and retired-instruction counter.
module multicycle_ctrl_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned OP_W        = 2,
   parameter int unsigned F3_W        = 3,
   parameter int unsigned MEM_TIMEOUT = 15,
   parameter int unsigned CNT_W       = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   multicycle_ctrl_fsm_if.slave  bus
);

   state_t           r_state;
   state_t           w_next;
   logic [CNT_W-1:0] r_instr_count;
   logic             r_timeout_err;
   logic [OP_W-1:0]  w_op;
   logic [F3_W-1:0]  w_f3;
   logic             w_mem_req;
   logic             w_wait;
   logic             w_timeout;
   logic             w_state_chg;
   logic             w_done;
   logic             w_run;

   assign w_op      = bus.op;
   assign w_f3      = bus.func_3;
   assign w_run     = !bus.stall;
   assign w_mem_req = is_mem_state(r_state);
   assign w_wait    = w_mem_req && !bus.mem_ready;

   ctrl_wait_timer #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_wait_timer (
      .clk         (clk),
      .reset       (reset),
      .i_en        (w_run),
      .i_wait      (w_wait),
      .i_state_chg (w_state_chg),
      .o_timeout   (w_timeout)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_FETCH;
      end else if (w_run) begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_FETCH:     if (bus.mem_ready) w_next = S_DECODE;
         S_DECODE: begin
            if      (w_op == OP_W'(OP_RTYPE)) w_next = S_EXECUTE_R;
            else if (w_op == OP_W'(OP_ITYPE)) w_next = S_EXECUTE_I;
            else if (w_op == OP_W'(OP_MEM))   w_next = S_MEM_ADR;
            else if (w_op == OP_W'(OP_BNEZ))  w_next = S_BNEZ;
            else                              w_next = S_TRAP;
         end
         S_MEM_ADR: begin
            if      (w_f3 == F3_W'(F3_LOAD))  w_next = S_MEM_READ;
            else if (w_f3 == F3_W'(F3_STORE)) w_next = S_MEM_WRITE;
            else                              w_next = S_TRAP;
         end
         S_MEM_READ:  if (bus.mem_ready) w_next = S_MEM_WB;
         S_MEM_WRITE: if (bus.mem_ready) w_next = S_FETCH;
         S_MEM_WB:    w_next = S_FETCH;
         S_EXECUTE_R: w_next = S_ALU_WB;
         S_EXECUTE_I: w_next = S_ALU_WB;
         S_ALU_WB:    w_next = S_FETCH;
         S_BNEZ:      w_next = S_FETCH;
         S_TRAP:      if (bus.trap_clr) w_next = S_FETCH;
         default:     w_next = S_FETCH;
      endcase
      // Timeout only fires while waiting, so it overrides the "stay" branches above.
      if (w_timeout) begin
         w_next = S_TRAP;
      end
   end

   assign w_state_chg = (w_next != r_state);

   assign w_done = w_run &&
                   ((r_state == S_MEM_WB) || (r_state == S_ALU_WB) || (r_state == S_BNEZ) ||
                    ((r_state == S_MEM_WRITE) && bus.mem_ready));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_instr_count <= '0;
         r_timeout_err <= 1'b0;
      end else if (w_run) begin
         if (w_done) begin
            r_instr_count <= r_instr_count + CNT_W'(1);
         end
         if (w_timeout) begin
            r_timeout_err <= 1'b1;
         end else if (bus.trap_clr) begin
            r_timeout_err <= 1'b0;
         end
      end
   end

   assign bus.state       = r_state;
   assign bus.mem_req     = w_mem_req;
   assign bus.instr_done  = w_done;
   assign bus.trap        = (r_state == S_TRAP);
   assign bus.timeout_err = r_timeout_err;
   assign bus.instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: hand-derived per-cycle expectations go
// through a queue and are compared against the DUT outputs on the falling edge.
module tb_multicycle_ctrl_fsm;

   localparam int unsigned OP_W  = 3;
   localparam int unsigned F3_W  = 3;
   localparam int unsigned TMO   = 4;
   localparam int unsigned CNT_W = 4;

   typedef logic [11:0] vec_t;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   multicycle_ctrl_fsm_if #(.OP_W(OP_W), .F3_W(F3_W), .CNT_W(CNT_W)) bus ();

   multicycle_ctrl_fsm #(
      .OP_W        (OP_W),
      .F3_W        (F3_W),
      .MEM_TIMEOUT (TMO),
      .CNT_W       (CNT_W)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   vec_t             exp_q[$];
   int unsigned      n_vec = 0;
   int unsigned      n_err = 0;
   logic [CNT_W-1:0] exp_cnt = '0;

   // {state, mem_req, instr_done, trap, timeout_err, instr_count}
   function automatic vec_t pack_exp(input logic [3:0] st, input logic done,
                                     input logic terr, input logic [CNT_W-1:0] cnt);
      logic req;
      req = (st == 4'd0) || (st == 4'd3) || (st == 4'd5);
      return {st, req, done, (st == 4'd10), terr, cnt};
   endfunction

   function automatic vec_t observed();
      return {bus.state, bus.mem_req, bus.instr_done, bus.trap, bus.timeout_err, bus.instr_count};
   endfunction

   task automatic chk(input string tag, input vec_t o, input vec_t e);
      n_vec++;
      assert (o === e) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic step(input string tag, input logic [2:0] op, input logic [2:0] f3,
                       input logic rdy, input logic stl, input logic clr,
                       input logic [3:0] e_st, input logic e_done, input logic e_terr);
      bus.op        = op;
      bus.func_3    = f3;
      bus.mem_ready = rdy;
      bus.stall     = stl;
      bus.trap_clr  = clr;
      exp_q.push_back(pack_exp(e_st, e_done, e_terr, exp_cnt));
      @(negedge clk);
      chk(tag, observed(), exp_q.pop_front());
      @(posedge clk);
      #1;
      if (e_done) exp_cnt = exp_cnt + 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset         = 1'b1;
      bus.op        = '0;
      bus.func_3    = '0;
      bus.mem_ready = 1'b0;
      bus.stall     = 1'b0;
      bus.trap_clr  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_state", observed(), pack_exp(4'd0, 1'b0, 1'b0, '0));
      reset = 1'b0;

      // R-type
      step("r_fetch",  0, 0, 1, 0, 0, 4'd0, 0, 0);
      step("r_decode", 0, 0, 0, 0, 0, 4'd1, 0, 0);
      step("r_exec",   0, 0, 0, 0, 0, 4'd6, 0, 0);
      step("r_alu_wb", 0, 0, 0, 0, 0, 4'd7, 1, 0);

      // Load with three wait cycles in MEM_READ
      step("ld_fetch",  2, 0, 1, 0, 0, 4'd0, 0, 0);
      step("ld_decode", 2, 0, 0, 0, 0, 4'd1, 0, 0);
      step("ld_adr",    2, 0, 0, 0, 0, 4'd2, 0, 0);
      for (int i = 0; i < 3; i++) step("ld_wait", 2, 0, 0, 0, 0, 4'd3, 0, 0);
      step("ld_ready",  2, 0, 1, 0, 0, 4'd3, 0, 0);
      step("ld_wb",     2, 0, 0, 0, 0, 4'd4, 1, 0);

      // Store completing on the second MEM_WRITE cycle
      step("st_fetch",  2, 1, 1, 0, 0, 4'd0, 0, 0);
      step("st_decode", 2, 1, 0, 0, 0, 4'd1, 0, 0);
      step("st_adr",    2, 1, 0, 0, 0, 4'd2, 0, 0);
      step("st_wait",   2, 1, 0, 0, 0, 4'd5, 0, 0);
      step("st_done",   2, 1, 1, 0, 0, 4'd5, 1, 0);

      // Illegal opcode traps until trap_clr
      step("iop_fetch",  5, 0, 1, 0, 0, 4'd0, 0, 0);
      step("iop_decode", 5, 0, 0, 0, 0, 4'd1, 0, 0);
      step("iop_trap0",  5, 0, 1, 0, 0, 4'd10, 0, 0);
      step("iop_trap1",  5, 0, 0, 0, 0, 4'd10, 0, 0);
      step("iop_clr",    5, 0, 0, 0, 1, 4'd10, 0, 0);

      // Illegal func_3
      step("if3_fetch",  2, 2, 1, 0, 0, 4'd0, 0, 0);
      step("if3_decode", 2, 2, 0, 0, 0, 4'd1, 0, 0);
      step("if3_adr",    2, 2, 0, 0, 0, 4'd2, 0, 0);
      step("if3_clr",    2, 2, 0, 0, 1, 4'd10, 0, 0);

      // Memory timeout in FETCH
      for (int i = 0; i < 5; i++) step("tmo_wait", 0, 0, 0, 0, 0, 4'd0, 0, 0);
      step("tmo_trap", 0, 0, 0, 0, 0, 4'd10, 0, 1);
      step("tmo_clr",  0, 0, 0, 0, 1, 4'd10, 0, 1);

      // Ready on the last permitted wait cycle wins over the timeout
      for (int i = 0; i < 4; i++) step("tmo_edge_wait", 1, 0, 0, 0, 0, 4'd0, 0, 0);
      step("tmo_edge_rdy", 1, 0, 1, 0, 0, 4'd0, 0, 0);
      step("it_decode",    1, 0, 0, 0, 0, 4'd1, 0, 0);

      // Stall in EXECUTE_I and in ALU_WB
      for (int i = 0; i < 3; i++) step("stall_exec", 1, 0, 0, 1, 0, 4'd8, 0, 0);
      step("it_exec",      1, 0, 0, 0, 0, 4'd8, 0, 0);
      step("stall_alu_wb", 1, 0, 0, 1, 0, 4'd7, 0, 0);
      step("it_alu_wb",    1, 0, 0, 0, 0, 4'd7, 1, 0);

      // BNEZ instructions until the counter wraps to zero
      for (int i = 0; i < 12; i++) begin
         step("bz_fetch",  3, 0, 1, 0, 0, 4'd0, 0, 0);
         step("bz_decode", 3, 0, 0, 0, 0, 4'd1, 0, 0);
         step("bz_exec",   3, 0, 0, 0, 0, 4'd9, 1, 0);
      end
      step("wrap_fetch",  3, 0, 1, 0, 0, 4'd0, 0, 0);
      step("wrap_decode", 3, 0, 0, 0, 0, 4'd1, 0, 0);
      step("wrap_exec",   3, 0, 0, 0, 0, 4'd9, 1, 0);

      // Asynchronous reset mid-cycle while in MEM_READ
      step("ar_fetch",  2, 0, 1, 0, 0, 4'd0, 0, 0);
      step("ar_decode", 2, 0, 0, 0, 0, 4'd1, 0, 0);
      step("ar_adr",    2, 0, 0, 0, 0, 4'd2, 0, 0);
      bus.mem_ready = 1'b0;
      #2;
      chk("ar_in_read", observed(), pack_exp(4'd3, 1'b0, 1'b0, 4'd1));
      reset = 1'b1;
      #1;
      exp_cnt = '0;
      chk("ar_async", observed(), pack_exp(4'd0, 1'b0, 1'b0, '0));
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      step("ar_post_fetch",  0, 0, 1, 0, 0, 4'd0, 0, 0);
      step("ar_post_decode", 0, 0, 0, 0, 0, 4'd1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
